// File: rtl/way_array_1h_if.sv
// Shared access bus of the multi-way RAM array: one address/data/enable set in,
// per-way registered read words and the one-hot muxed word out.
interface way_array_1h_if #(
    parameter int unsigned NUM_WAY    = 2,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WE_WIDTH   = 1
);
    logic [ADDR_WIDTH-1:0]        addr;
    logic [WIDTH-1:0]             din;
    logic [NUM_WAY*WE_WIDTH-1:0]  we;
    logic [NUM_WAY-1:0]           select;
    logic [NUM_WAY*WIDTH-1:0]     dout_all;
    logic [WIDTH-1:0]             dout;

    modport master (
        output addr, din, we, select,
        input  dout_all, dout
    );

    modport slave (
        input  addr, din, we, select,
        output dout_all, dout
    );
endinterface

// File: rtl/way_array_1h.sv
// NUM_WAY independent read-first single-port RAMs on a shared address/data bus,
// with optional byte enables and a one-hot AND-OR selector on the read words.
module way_array_1h #(
    parameter int unsigned NUM_WAY    = 2,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned WRITE_BYTE = 0
) (
    input  logic          clk,
    input  logic          reset,
    way_array_1h_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned WE_WIDTH   = (WRITE_BYTE != 0) ? WIDTH / 8 : 1;
    localparam int unsigned LANE_BITS  = (WRITE_BYTE != 0) ? 8 : WIDTH;

    logic [WIDTH-1:0]              mem_q [NUM_WAY][DEPTH];
    logic [NUM_WAY-1:0][WIDTH-1:0] rd_q;
    logic [WIDTH-1:0]              dout_c;

    // Read-first: the output register samples the pre-write contents; reset blocks writes only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            for (int w = 0; w < int'(NUM_WAY); w++) begin
                rd_q[w] <= mem_q[w][bus.addr];
                for (int l = 0; l < int'(WE_WIDTH); l++) begin
                    if (bus.we[w*WE_WIDTH + l]) begin
                        mem_q[w][bus.addr][l*LANE_BITS +: LANE_BITS] <= bus.din[l*LANE_BITS +: LANE_BITS];
                    end
                end
            end
        end
    end

    // AND-OR selector; several select bits OR their ways together.
    always_comb begin
        dout_c = '0;
        for (int w = 0; w < int'(NUM_WAY); w++) begin
            dout_c = dout_c | (rd_q[w] & {WIDTH{bus.select[w]}});
        end
    end

    assign bus.dout_all = rd_q;
    assign bus.dout     = dout_c;

    // ADDR_WIDTH documents the bus width expected from the interface instance.
    logic unused_addr_width_c;
    assign unused_addr_width_c = (ADDR_WIDTH == 0);
endmodule

// File: tb/tb_way_array_1h.sv
// Directed bench for way_array_1h: one word-enable and one byte-enable instance
// driven through their interfaces, checked against hand-computed words.
module tb_way_array_1h;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    way_array_1h_if #(.NUM_WAY(2), .WIDTH(32), .ADDR_WIDTH(8), .WE_WIDTH(1)) a_if ();
    way_array_1h_if #(.NUM_WAY(2), .WIDTH(32), .ADDR_WIDTH(8), .WE_WIDTH(4)) b_if ();

    way_array_1h #(.NUM_WAY(2), .DEPTH(256), .WIDTH(32), .WRITE_BYTE(0)) u_dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    way_array_1h #(.NUM_WAY(2), .DEPTH(256), .WIDTH(32), .WRITE_BYTE(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a_if.addr = '0; a_if.din = '0; a_if.we = '0; a_if.select = '0;
        b_if.addr = '0; b_if.din = '0; b_if.we = '0; b_if.select = '0;
        tick();
        tick();
        chk("reset_dout_all_w", 64'(a_if.dout_all), 64'h0);
        a_if.select = 2'b11;
        #1;
        chk("reset_dout_w", 64'(a_if.dout), 64'h0);
        chk("reset_dout_all_b", 64'(b_if.dout_all), 64'h0);

        // Bring every entry to a known zero state in both instances.
        reset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            a_if.addr = 8'(a); a_if.din = '0; a_if.we = 2'b11;
            b_if.addr = 8'(a); b_if.din = '0; b_if.we = 8'hFF;
            tick();
        end
        a_if.we = '0;
        b_if.we = '0;

        // Two ways at the same address, then the selector.
        a_if.addr = 8'h10; a_if.din = 32'hDEADBEEF; a_if.we = 2'b01; tick();
        a_if.din = 32'h12345678; a_if.we = 2'b10; tick();
        a_if.we = 2'b00; tick();
        chk("rd_0x10_all", 64'(a_if.dout_all), 64'h12345678_DEADBEEF);
        a_if.select = 2'b01; #1;
        chk("sel01", 64'(a_if.dout), 64'hDEADBEEF);
        a_if.select = 2'b10; #1;
        chk("sel10", 64'(a_if.dout), 64'h12345678);
        a_if.select = 2'b00; #1;
        chk("sel00", 64'(a_if.dout), 64'h0);
        a_if.select = 2'b11; #1;
        chk("sel11_or", 64'(a_if.dout), 64'hDEBDFEFF);

        // Read-during-write on the same way and address returns the old word.
        a_if.addr = 8'h03; a_if.din = 32'h1; a_if.we = 2'b01; tick();
        a_if.din = 32'h2; a_if.we = 2'b01; tick();
        chk("collision_old", 64'(a_if.dout_all), 64'h00000000_00000001);
        a_if.we = 2'b00; tick();
        chk("collision_new", 64'(a_if.dout_all), 64'h00000000_00000002);

        // Way isolation and simultaneous multi-way write.
        a_if.addr = 8'h07; a_if.din = 32'hCAFEF00D; a_if.we = 2'b10; tick();
        a_if.we = 2'b00; tick();
        chk("isolate_0x07", 64'(a_if.dout_all), 64'hCAFEF00D_00000000);
        a_if.addr = 8'h08; a_if.din = 32'h55AA33CC; a_if.we = 2'b11; tick();
        a_if.we = 2'b00; tick();
        chk("both_ways_0x08", 64'(a_if.dout_all), 64'h55AA33CC_55AA33CC);

        // Address boundaries.
        a_if.addr = 8'h00; a_if.din = 32'hA5A5A5A5; a_if.we = 2'b01; tick();
        a_if.addr = 8'hFF; a_if.din = 32'h5A5A5A5A; a_if.we = 2'b10; tick();
        a_if.addr = 8'h00; a_if.we = 2'b00; tick();
        chk("addr_min", 64'(a_if.dout_all), 64'h00000000_A5A5A5A5);
        a_if.addr = 8'hFF; tick();
        chk("addr_max", 64'(a_if.dout_all), 64'h5A5A5A5A_00000000);
        a_if.select = 2'b10; #1;
        chk("addr_max_sel", 64'(a_if.dout), 64'h5A5A5A5A);

        // Reset clears the read registers and blocks writes.
        reset = 1'b1;
        a_if.addr = 8'h09; a_if.din = 32'hAAAA5555; a_if.we = 2'b11;
        b_if.addr = 8'h09; b_if.din = 32'hAAAA5555; b_if.we = 8'hFF;
        tick();
        chk("reset_clr_all", 64'(a_if.dout_all), 64'h0);
        a_if.select = 2'b11; #1;
        chk("reset_clr_dout", 64'(a_if.dout), 64'h0);
        tick();
        reset = 1'b0;
        a_if.we = 2'b00; b_if.we = 8'h00;
        tick();
        chk("reset_no_write_w", 64'(a_if.dout_all), 64'h0);
        chk("reset_no_write_b", 64'(b_if.dout_all), 64'h0);
        a_if.addr = 8'h10; tick();
        chk("retained_0x10", 64'(a_if.dout_all), 64'h12345678_DEADBEEF);
        a_if.addr = 8'hFF; tick();
        chk("retained_0xFF", 64'(a_if.dout_all), 64'h5A5A5A5A_00000000);

        // Byte enables: lanes 0 and 2 of way0, then lanes 1 and 3 of way1.
        b_if.addr = 8'h05; b_if.din = 32'hFFFFFFFF; b_if.we = 8'h0F; tick();
        b_if.din = 32'h00AA0011; b_if.we = 8'h05; tick();
        b_if.we = 8'h00; tick();
        chk("byte_way0", 64'(b_if.dout_all), 64'h00000000_FFAAFF11);
        b_if.select = 2'b01; #1;
        chk("byte_way0_sel", 64'(b_if.dout), 64'hFFAAFF11);
        b_if.addr = 8'h06; b_if.din = 32'h12345678; b_if.we = 8'hA0; tick();
        b_if.we = 8'h00; tick();
        chk("byte_way1", 64'(b_if.dout_all), 64'h12005600_00000000);
        b_if.select = 2'b10; #1;
        chk("byte_way1_sel", 64'(b_if.dout), 64'h12005600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/way_array_1h.md
# way_array_1h

Multi-way synchronous block-RAM array with a one-hot output selector, used as the storage core of the cache tables (tag/valid arrays and data banks). It holds NUM_WAY independent single-port RAMs sharing one address and one write-data bus. Each way has its own write enable, optionally per byte. A one-hot AND-OR multiplexer picks one way's registered read word.

## Interface
Parameters:
- NUM_WAY, 2, number of ways (independent RAMs); ≥1
- DEPTH, 256, entries per way; power of two ≥2
- WIDTH, 32, bits per entry
- WRITE_BYTE, 0, 1 = per-byte write enables (WIDTH must be a multiple of 8); 0 = one enable per way
- ADDR_WIDTH, $clog2(DEPTH), derived
- WE_WIDTH, WRITE_BYTE ? WIDTH/8 : 1, derived

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- addr  in  ADDR_WIDTH  shared read/write address for all ways
- din  in  WIDTH  shared write data
- we  in  NUM_WAY*WE_WIDTH  write enables; way i uses we[i*WE_WIDTH +: WE_WIDTH]
- select  in  NUM_WAY  one-hot way select for dout
- dout_all  out  NUM_WAY*WIDTH  registered read word of every way; way i at [i*WIDTH +: WIDTH]
- dout  out  WIDTH  AND-OR of dout_all under select

## Operation
- Each way is a DEPTH×WIDTH RAM with one port. Every cycle it reads mem[addr] into that way's output register.
- Write, WRITE_BYTE=0: if the way's enable is 1, mem[addr] <= din.
- Write, WRITE_BYTE=1: byte k (bits 8k+7:8k) is written only when enable bit k is 1. Other bytes are preserved.
- Read-during-write, same way and address: the output register takes the OLD contents (read-first).
- Ways are fully independent. Several ways may be written in the same cycle with the same addr/din.
- Memory contents initialise to all zeros at configuration. Reset does not clear memory.
- While reset=1:
  - every way's output register loads 0;
  - all writes are suppressed, even if we is set.
- Output mux, purely combinational: dout = OR over i of (dout_all way i AND {WIDTH{select[i]}}).
  - select = 0: dout = 0.
  - Multiple select bits set: dout is the bitwise OR of the selected ways. Not an error; callers keep select one-hot.
- No handshake. The block accepts an access every cycle.

## Timing
- Read latency 1 cycle: addr presented at edge N appears on dout_all after edge N.
- dout follows select combinationally, with no added latency. Select is normally derived in the cycle after the address (e.g. from tag compare on dout_all).
- Write takes effect at the edge where we is sampled. A read of that address issued at the next edge returns the new data.
- Output registers hold their value only until the next edge. Every edge performs a read, so dout_all always reflects the previous cycle's addr.
- Reset values: dout_all = 0; dout = 0 for any select.
- Reset released mid-sequence: the first post-reset edge performs a normal read/write. No memory contents are lost.

## Test plan
- Write/read, WRITE_BYTE=0, NUM_WAY=2: write 0xDEADBEEF to way0 @0x10 and 0x12345678 to way1 @0x10. Read 0x10 -> next cycle dout_all = {0x12345678, 0xDEADBEEF}; select=01 -> dout=0xDEADBEEF; select=10 -> dout=0x12345678; select=00 -> dout=0.
- Byte write, WRITE_BYTE=1: write 0xFFFFFFFF @5 to way0, then din=0x00AA0011 with way0 we=0101. Read @5 -> 0xFFAAFF11.
- Read-first collision: mem@3 = 0x1. Write 0x2 @3 while reading @3 -> output 0x1 that cycle. Read again -> 0x2.
- Way isolation: write way1 only @7. Way0 @7 remains 0 (initial). Writes to two ways at once both land.
- Reset: hold reset with we all-ones, din=0xAAAA5555, at addr 9 -> dout_all = 0 and mem@9 unchanged (reads 0 after reset). Prior data at other addresses is still readable after reset drops.
- Boundaries: write/read addr 0 and DEPTH-1 with distinct values. Exercise select with two bits set -> dout = OR of both words.
